arb_req_collector: RTL and testbench
====================================

# arb_req_collector

Per-requester request accumulator that sits directly upstream of the 5-input, 2-grant arbiter. Captures single-cycle request pulses from five sources into saturating outstanding-request counters, presents a registered request vector and `valid` to the arbiter, and retires one outstanding request per source for each grant returned on the arbiter's `grant_out`. It flags overflow and spurious grants, and can optionally flag starving requesters.

## Interface
- `N_REQ`, 5: number of requesters; must match the arbiter width.
- `CNT_W`, 3: outstanding-counter width; maximum `2**CNT_W-1` (7) pending per source.
- `AGE_W`, 4: age-counter width (only used with `REQ_AGE_EN`).
- `AGE_LIMIT`, 12: pending cycles without a grant before `urgent_out` asserts; must be `< 2**AGE_W`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_pulse_in`, in, N_REQ: each set bit is one new request from that source in that cycle.
- `grant_in`, in, N_REQ: the arbiter's `grant_out`; at most 2 bits are set.
- `req_out`, out, N_REQ: to the arbiter's `req_in`; bit i means counter i is nonzero.
- `valid_out`, out, 1: to the arbiter's `valid`; equals `|req_out`.
- `full_out`, out, N_REQ: counter i is at its maximum.
- `ovf_out`, out, 1: sticky; a request was dropped because its counter was full.
- `spur_out`, out, 1: sticky; a grant arrived for a source whose counter was zero.
- `err_clr_in`, in, 1: synchronous clear of `ovf_out` and `spur_out`.
- `urgent_out`, out, N_REQ: bit i means source i has been pending at least `AGE_LIMIT` cycles. Present only with `REQ_AGE_EN`.

## Operation
- Each source has a counter `cnt[i]`. Per cycle, with `r = req_pulse_in[i]` and `g = grant_in[i]`:
  - `r & !g`: increment. If `cnt[i]` is already at max, hold, drop the request and set `ovf_out`.
  - `!r & g`: decrement. If `cnt[i] == 0`, hold and set `spur_out`.
  - `r & g`: hold. This is net zero even when the counter is full. If the counter is zero, it becomes 1 (the grant counts as spurious, set `spur_out`, and the request is kept).
  - Neither: hold.
- `req_out[i] = (cnt[i] != 0)` and `full_out[i] = (cnt[i] == max)`, both decoded from the registered counters.
- `err_clr_in` has priority over a same-cycle set: the flags clear that cycle, and an error in the same cycle is lost.
- Sources are fully independent; any number may pulse in the same cycle.
- No arithmetic wraps; all counters saturate.

## Timing
- Reset values: every `cnt` and age counter is 0, so `req_out = 0`, `valid_out = 0`, `full_out = 0`, `ovf_out = 0`, `spur_out = 0`, `urgent_out = 0`.
- Request to `req_out` latency: 1 cycle. A pulse at edge t gives `req_out[i]` high after edge t.
- Grant to retire latency: 1 cycle. The arbiter's grant registered at edge t takes effect on `cnt` at edge t+1.
- A source with `cnt == 1` may receive a second grant while its bit drops. That grant is spurious, is ignored, and sets `spur_out`. The integration must tolerate this; the arbiter does not stall.
- Asserting reset mid-operation clears everything immediately (asynchronously). Pending requests are lost.

## Configuration
- `REQ_AGE_EN` defined:
  - Each source has an `AGE_W` age counter.
  - The counter is cleared when `cnt` is 0 or when `grant_in[i]` is set; otherwise it increments, saturating at `2**AGE_W-1`.
  - `urgent_out[i] = (age >= AGE_LIMIT)`.
- `REQ_AGE_EN` undefined: the age counters, the `urgent_out` port and the `AGE_W`/`AGE_LIMIT` logic are absent.

## Structure
- Shared package `arb_pkg` holds:
  - `N_REQ`, and `typedef logic [N_REQ-1:0] req_vec_t`, which is also used by the arbiter.
  - `CNT_W` default, and the `cnt_t` typedef.
- Sub-module `arb_req_counter`: one saturating counter, its flag outputs, and the optional age counter. It is instantiated N_REQ times by generate.
- The top level ORs the per-source `ovf`/`spur` pulses into the two sticky flags.

## Test plan
- Reset, then idle 3 cycles: `req_out = 5'h00`, `valid_out = 0`, all flags 0.
- Pulse `req_pulse_in = 5'h1a` for 1 cycle: next cycle `req_out = 5'h1a` and `valid_out = 1`. Then `grant_in = 5'h18` gives `req_out = 5'h02`, and `grant_in = 5'h02` gives `req_out = 5'h00`.
- Pulse source 0 eight consecutive cycles with no grant:
  - `cnt[0]` saturates at 7 and `full_out = 5'h01`.
  - `ovf_out` rises on the 8th pulse.
  - `err_clr_in` clears `ovf_out` the next cycle.
- Hold `req_pulse_in = 5'h04` and `grant_in = 5'h04` together for 4 cycles, starting from `cnt[2] = 1`: `cnt[2]` stays 1, `req_out[2]` stays 1, no flags.
- `grant_in = 5'h10` with `cnt[4] = 0`: `spur_out = 1`, `cnt[4]` stays 0. Then assert `rst_n = 0` mid-stream with several counters nonzero: all outputs are 0 immediately.
- With `REQ_AGE_EN`: pend source 3 with no grant. `urgent_out = 5'h08` after exactly 12 cycles pending. A grant clears it the next cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared request-vector and counter types for the collector and arbiter; age sizing under REQ_AGE_EN
package arb_pkg;

   localparam int N_REQ = 5;
   localparam int CNT_W = 3;

   typedef logic [N_REQ-1:0] req_vec_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

`ifdef REQ_AGE_EN
   localparam int AGE_W = 4;

   typedef logic [AGE_W-1:0] age_t;

   localparam age_t AGE_MAX   = {AGE_W{1'b1}};
   localparam age_t AGE_LIMIT = age_t'(12);
`endif

endpackage

// File: rtl/arb_req_counter.sv
// rtl/arb_req_counter.sv - one saturating outstanding-request counter with error pulses; age counter under REQ_AGE_EN
module arb_req_counter
   import arb_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_i,
   input  logic grant_i,
   output logic nz_o,
   output logic full_o,
   output logic ovf_o,
   output logic spur_o
`ifdef REQ_AGE_EN
   ,
   output logic urgent_o
`endif
);

   cnt_t cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      ovf_o  = 1'b0;
      spur_o = 1'b0;
      case ({req_i, grant_i})
         2'b10: begin
            if (cnt_q == CNT_MAX) ovf_o = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
         end
         2'b01: begin
            if (cnt_q == '0) spur_o = 1'b1;
            else             cnt_d  = cnt_q - 1'b1;
         end
         2'b11: begin
            // Grant on an empty counter is spurious, but the same-cycle request is kept.
            if (cnt_q == '0) begin
               spur_o = 1'b1;
               cnt_d  = cnt_t'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign nz_o   = (cnt_q != '0);
   assign full_o = (cnt_q == CNT_MAX);

`ifdef REQ_AGE_EN
   age_t age_q, age_d;

   always_comb begin
      age_d = age_q;
      if ((cnt_q == '0) || grant_i) age_d = '0;
      else if (age_q != AGE_MAX)    age_d = age_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) age_q <= '0;
      else        age_q <= age_d;
   end

   assign urgent_o = (age_q >= AGE_LIMIT);
`endif

endmodule

// File: rtl/arb_req_collector.sv
// rtl/arb_req_collector.sv - per-source request accumulator feeding the arbiter; urgent_out present under REQ_AGE_EN
module arb_req_collector
   import arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_pulse_in,
   input  logic [N_REQ-1:0] grant_in,
   input  logic             err_clr_in,
   output logic [N_REQ-1:0] req_out,
   output logic             valid_out,
   output logic [N_REQ-1:0] full_out,
   output logic             ovf_out,
   output logic             spur_out
`ifdef REQ_AGE_EN
   ,
   output logic [N_REQ-1:0] urgent_out
`endif
);

   req_vec_t ovf_ev, spur_ev;
   logic     ovf_q, ovf_d;
   logic     spur_q, spur_d;

   for (genvar i = 0; i < N_REQ; i++) begin : g_src
      arb_req_counter u_cnt (
         .clk     (clk),
         .rst_n   (rst_n),
         .req_i   (req_pulse_in[i]),
         .grant_i (grant_in[i]),
         .nz_o    (req_out[i]),
         .full_o  (full_out[i]),
         .ovf_o   (ovf_ev[i]),
         .spur_o  (spur_ev[i])
`ifdef REQ_AGE_EN
         ,
         .urgent_o(urgent_out[i])
`endif
      );
   end

   // Clear wins over a same-cycle error event.
   always_comb begin
      ovf_d  = ovf_q | (|ovf_ev);
      spur_d = spur_q | (|spur_ev);
      if (err_clr_in) begin
         ovf_d  = 1'b0;
         spur_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         spur_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         spur_q <= spur_d;
      end
   end

   assign valid_out = |req_out;
   assign ovf_out   = ovf_q;
   assign spur_out  = spur_q;

endmodule

// File: tb/tb_arb_req_collector.sv
// tb/tb_arb_req_collector.sv - randomized bench for arb_req_collector against a behavioural model; urgent checks under REQ_AGE_EN
module tb_arb_req_collector;

   localparam int N   = 5;
   localparam int MAX = 7;
   localparam int AMX = 15;
   localparam int LIM = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req_pulse_in = '0;
   logic [N-1:0] grant_in = '0;
   logic         err_clr_in = 1'b0;
   logic [N-1:0] req_out;
   logic         valid_out;
   logic [N-1:0] full_out;
   logic         ovf_out;
   logic         spur_out;
   logic [N-1:0] urgent_out;

   arb_req_collector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_pulse_in(req_pulse_in),
      .grant_in    (grant_in),
      .err_clr_in  (err_clr_in),
      .req_out     (req_out),
      .valid_out   (valid_out),
      .full_out    (full_out),
      .ovf_out     (ovf_out),
      .spur_out    (spur_out)
`ifdef REQ_AGE_EN
      ,
      .urgent_out  (urgent_out)
`endif
   );

`ifndef REQ_AGE_EN
   assign urgent_out = '0;
`endif

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   int m_cnt [N];
   int m_age [N];
   bit m_ovf, m_spur;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] exp_req();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = (m_cnt[i] != 0);
      return v;
   endfunction

   function automatic logic [N-1:0] exp_full();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = (m_cnt[i] == MAX);
      return v;
   endfunction

   function automatic logic [N-1:0] exp_urgent();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = (m_age[i] >= LIM);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0;
         m_age[i] = 0;
      end
      m_ovf  = 1'b0;
      m_spur = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] g, input logic clr);
      bit ovf_ev = 1'b0;
      bit spur_ev = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (m_cnt[i] == 0 || g[i]) m_age[i] = 0;
         else if (m_age[i] < AMX)   m_age[i] = m_age[i] + 1;
         if (r[i] && !g[i]) begin
            if (m_cnt[i] == MAX) ovf_ev = 1'b1;
            else m_cnt[i] = m_cnt[i] + 1;
         end else if (!r[i] && g[i]) begin
            if (m_cnt[i] == 0) spur_ev = 1'b1;
            else m_cnt[i] = m_cnt[i] - 1;
         end else if (r[i] && g[i] && m_cnt[i] == 0) begin
            spur_ev  = 1'b1;
            m_cnt[i] = 1;
         end
      end
      if (clr) begin
         m_ovf  = 1'b0;
         m_spur = 1'b0;
      end else begin
         m_ovf  = m_ovf | ovf_ev;
         m_spur = m_spur | spur_ev;
      end
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] g, input logic clr);
      req_pulse_in = r;
      grant_in     = g;
      err_clr_in   = clr;
      @(posedge clk);
      model_step(r, g, clr);
      #1;
      req_pulse_in = '0;
      grant_in     = '0;
      err_clr_in   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      check("rst_req_out", req_out, 0);
      check("rst_full_out", full_out, 0);
      check("rst_flags", {valid_out, ovf_out, spur_out}, 0);
      model_reset();
      @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("req_out", req_out, exp_req());
         check("valid_out", valid_out, |exp_req());
         check("full_out", full_out, exp_full());
         check("ovf_out", ovf_out, m_ovf);
         check("spur_out", spur_out, m_spur);
`ifdef REQ_AGE_EN
         check("urgent_out", urgent_out, exp_urgent());
`endif
      end
   end

   initial begin
      logic [N-1:0] r, g;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      repeat (3) cycle('0, '0, 1'b0);
      check("idle_req", req_out, 5'h00);
      check("idle_flags", {valid_out, full_out, ovf_out, spur_out}, 0);

      cycle(5'h1a, '0, 1'b0);
      check("pulse_req", req_out, 5'h1a);
      check("pulse_valid", valid_out, 1'b1);
      check("model_pulse_req", exp_req(), 5'h1a);
      cycle('0, 5'h18, 1'b0);
      check("grant18_req", req_out, 5'h02);
      cycle('0, 5'h02, 1'b0);
      check("grant02_req", req_out, 5'h00);
      check("grant_no_spur", spur_out, 1'b0);

      for (int k = 1; k <= 8; k++) begin
         cycle(5'h01, '0, 1'b0);
         if (k == 7) begin
            check("sat_full", full_out, 5'h01);
            check("sat_no_ovf", ovf_out, 1'b0);
         end
      end
      check("sat_ovf", ovf_out, 1'b1);
      check("model_cnt0", m_cnt[0], MAX);
      cycle('0, '0, 1'b1);
      check("clr_ovf", ovf_out, 1'b0);
      check("clr_keeps_full", full_out, 5'h01);

      cycle(5'h04, '0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         cycle(5'h04, 5'h04, 1'b0);
         check("hold_req", req_out, 5'h05);
         check("hold_flags", {ovf_out, spur_out}, 0);
      end
      check("model_cnt2", m_cnt[2], 1);

      cycle('0, 5'h10, 1'b0);
      check("spur_flag", spur_out, 1'b1);
      check("spur_req", req_out, 5'h05);
      cycle(5'h1f, '0, 1'b0);
      do_reset();

`ifdef REQ_AGE_EN
      cycle(5'h08, '0, 1'b0);
      for (int k = 1; k <= 12; k++) begin
         cycle('0, '0, 1'b0);
         if (k == 11) check("age_11", urgent_out, 5'h00);
      end
      check("age_12", urgent_out, 5'h08);
      cycle('0, 5'h08, 1'b0);
      check("age_grant", urgent_out, 5'h00);
      check("age_grant_req", req_out, 5'h00);
`endif

      for (int c = 0; c < 3000; c++) begin
         if (c % 500 < 200) r = N'($urandom_range(0, 31));
         else               r = N'($urandom_range(0, 31) & $urandom_range(0, 31) & $urandom_range(0, 31));
         g = '0;
         for (int k = 0, n = $urandom_range(0, 2); k < n; k++) begin
            int idx = $urandom_range(0, N - 1);
            if ($urandom_range(0, 4) != 0) begin
               for (int t = 0; t < 8 && m_cnt[idx] == 0; t++) idx = $urandom_range(0, N - 1);
            end
            g[idx] = 1'b1;
         end
         if (c % 700 < 150) g = '0;
         cycle(r, g, ($urandom_range(0, 15) == 0));
         if (c == 1500) do_reset();
      end

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
